// File: rtl/turkey_gun_pkg.sv
// Shared types and position limits for the turkey gun crosshair logic.
package turkey_gun_pkg;

    typedef logic [5:0] gun_pos_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } axis_st_t;

    localparam gun_pos_t GUN_MIN = 6'd0;
    localparam gun_pos_t GUN_MAX = 6'd63;

endpackage

// File: rtl/turkey_gun_pos_if.sv
// Joystick-in / crosshair-out signal bundle between hps_io and williams2.
interface turkey_gun_pos_if;
    logic       cnt_4ms;
    logic       analog_en;
    logic       recenter;
    logic       joy_left;
    logic       joy_right;
    logic       joy_up;
    logic       joy_down;
    logic [7:0] joy_x;
    logic [7:0] joy_y;
    logic [5:0] gun_h;
    logic [5:0] gun_v;
    logic       gun_update;

    modport master (
        output cnt_4ms, analog_en, recenter,
        output joy_left, joy_right, joy_up, joy_down, joy_x, joy_y,
        input  gun_h, gun_v, gun_update
    );

    modport slave (
        input  cnt_4ms, analog_en, recenter,
        input  joy_left, joy_right, joy_up, joy_down, joy_x, joy_y,
        output gun_h, gun_v, gun_update
    );
endinterface

// File: rtl/turkey_gun_axis.sv
// One crosshair axis: digital hold-to-repeat FSM with acceleration, or analog slew.
module turkey_gun_axis
    import turkey_gun_pkg::*;
#(
    parameter int unsigned STEP_DIV    = 4,
    parameter int unsigned ACCEL_STEPS = 8,
    parameter int unsigned SLEW_MAX    = 4,
    parameter int unsigned CENTER      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       recenter,
    input  logic       analog_en,
    input  logic       dir_neg,
    input  logic       dir_pos,
    input  logic [7:0] joy,
    output gun_pos_t   pos,
    output logic       moved
);
    localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned SW = $clog2(ACCEL_STEPS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(STEP_DIV - 1);
    localparam logic [SW-1:0] STEPS_END = SW'(ACCEL_STEPS);
    localparam logic signed [6:0] SLEW  = 7'(SLEW_MAX);

    axis_st_t          state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [SW-1:0]     steps_q, steps_d;
    logic              held_q, held_d;  // 1 = positive direction latched on entering HOLD
    gun_pos_t          pos_q, pos_d;
    gun_pos_t          target;
    logic signed [6:0] diff, delta;
    logic              dir_ok, reversed, step;

    assign dir_ok   = dir_neg ^ dir_pos;
    assign reversed = dir_pos != held_q;
    assign target   = {~joy[7], joy[6:2]};
    assign diff     = $signed({1'b0, target}) - $signed({1'b0, pos_q});

    always_comb begin
        delta = diff;
        if (diff > SLEW)
            delta = SLEW;
        else if (diff < -SLEW)
            delta = -SLEW;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        steps_d = steps_q;
        held_d  = held_q;
        pos_d   = pos_q;
        step    = 1'b0;
        if (recenter) begin
            state_d = IDLE;
            div_d   = '0;
            steps_d = '0;
            pos_d   = gun_pos_t'(CENTER);
        end else if (tick) begin
            if (analog_en) begin
                state_d = IDLE;
                div_d   = '0;
                steps_d = '0;
                pos_d   = pos_q + gun_pos_t'(delta);
            end else begin
                case (state_q)
                    IDLE: begin
                        if (dir_ok) begin
                            state_d = HOLD;
                            div_d   = '0;
                            held_d  = dir_pos;
                        end
                    end
                    HOLD: begin
                        if (!dir_ok || reversed) begin
                            state_d = IDLE;
                            div_d   = '0;
                            steps_d = '0;
                        end else begin
                            step  = (div_q == '0);
                            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                            if (step) begin
                                steps_d = steps_q + 1'b1;
                                if (steps_d == STEPS_END)
                                    state_d = REPEAT;
                            end
                        end
                    end
                    REPEAT: begin
                        if (!dir_ok || reversed) begin
                            state_d = IDLE;
                            div_d   = '0;
                            steps_d = '0;
                        end else begin
                            step = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
                // A saturated step still counts toward acceleration but leaves pos alone
                if (step) begin
                    if (held_q)
                        pos_d = (pos_q == GUN_MAX) ? pos_q : pos_q + 6'd1;
                    else
                        pos_d = (pos_q == GUN_MIN) ? pos_q : pos_q - 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            steps_q <= '0;
            held_q  <= 1'b0;
            pos_q   <= gun_pos_t'(CENTER);
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            steps_q <= steps_d;
            held_q  <= held_d;
            pos_q   <= pos_d;
        end
    end

    assign pos   = pos_q;
    assign moved = pos_d != pos_q;

endmodule

// File: rtl/turkey_gun_pos.sv
// Player-1 joystick to williams2 gun_h/gun_v crosshair, advanced on cnt_4ms rising edges.
module turkey_gun_pos
    import turkey_gun_pkg::*;
#(
    parameter int unsigned STEP_DIV    = 4,
    parameter int unsigned ACCEL_STEPS = 8,
    parameter int unsigned SLEW_MAX    = 4,
    parameter int unsigned CENTER      = 32
) (
    input  logic             clock_12,
    input  logic             reset_n,
    turkey_gun_pos_if.slave  bus
);
    logic     cnt_r, tick;
    logic     h_moved, v_moved, update_q;
    gun_pos_t h_pos, v_pos;

    assign tick = bus.cnt_4ms & ~cnt_r;

    turkey_gun_axis #(
        .STEP_DIV    (STEP_DIV),
        .ACCEL_STEPS (ACCEL_STEPS),
        .SLEW_MAX    (SLEW_MAX),
        .CENTER      (CENTER)
    ) u_axis_h (
        .clk       (clock_12),
        .rst_n     (reset_n),
        .tick      (tick),
        .recenter  (bus.recenter),
        .analog_en (bus.analog_en),
        .dir_neg   (bus.joy_left),
        .dir_pos   (bus.joy_right),
        .joy       (bus.joy_x),
        .pos       (h_pos),
        .moved     (h_moved)
    );

    turkey_gun_axis #(
        .STEP_DIV    (STEP_DIV),
        .ACCEL_STEPS (ACCEL_STEPS),
        .SLEW_MAX    (SLEW_MAX),
        .CENTER      (CENTER)
    ) u_axis_v (
        .clk       (clock_12),
        .rst_n     (reset_n),
        .tick      (tick),
        .recenter  (bus.recenter),
        .analog_en (bus.analog_en),
        .dir_neg   (bus.joy_up),
        .dir_pos   (bus.joy_down),
        .joy       (bus.joy_y),
        .pos       (v_pos),
        .moved     (v_moved)
    );

    always_ff @(posedge clock_12 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            cnt_r    <= bus.cnt_4ms;
            update_q <= h_moved | v_moved;
        end
    end

    assign bus.gun_h      = h_pos;
    assign bus.gun_v      = v_pos;
    assign bus.gun_update = update_q;

endmodule

// File: tb/tb_turkey_gun_pos.sv
// Directed and randomized checks of turkey_gun_pos against a tick-count reference model.
module tb_turkey_gun_pos;
    localparam int STEP_DIV    = 4;
    localparam int ACCEL_STEPS = 8;
    localparam int SLEW_MAX    = 4;
    localparam int CENTER      = 32;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    // Model: position plus count of consecutive ticks holding the same direction
    int mh, mv, nh, nv;
    bit hh, hv;

    turkey_gun_pos_if bus ();

    turkey_gun_pos #(
        .STEP_DIV    (STEP_DIV),
        .ACCEL_STEPS (ACCEL_STEPS),
        .SLEW_MAX    (SLEW_MAX),
        .CENTER      (CENTER)
    ) dut (
        .clock_12 (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit step_due(input int n);
        int k;
        if (n < 2) return 1'b0;
        k = n - 2;
        if (k <= (ACCEL_STEPS - 1) * STEP_DIV) return (k % STEP_DIV) == 0;
        return 1'b1;
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : (x > hi) ? hi : x;
    endfunction

    task automatic model_axis(input bit an, input bit ng, input bit ps, input logic [7:0] j,
                              inout int p, inout int n, inout bit held);
        int jv, tgt;
        if (an) begin
            n   = 0;
            jv  = int'($signed(j));
            tgt = (jv + 128) / 4;
            p   = p + clamp(tgt - p, -SLEW_MAX, SLEW_MAX);
        end else if (ng ^ ps) begin
            if (n > 0 && ps != held) begin
                n = 0;
            end else begin
                if (n == 0) held = ps;
                n++;
                if (step_due(n)) p = clamp(p + (ps ? 1 : -1), 0, 63);
            end
        end else begin
            n = 0;
        end
    endtask

    task automatic model_reset();
        mh = CENTER; mv = CENTER; nh = 0; nv = 0; hh = 0; hv = 0;
    endtask

    task automatic check_pos(input string tag, input bit upd);
        chk({tag, "_h"}, 8'(bus.gun_h), 8'(mh));
        chk({tag, "_v"}, 8'(bus.gun_v), 8'(mv));
        chk({tag, "_upd"}, 8'(bus.gun_update), 8'(upd));
    endtask

    task automatic do_tick(input bit rc);
        int oh, ov, extra;
        bit upd;
        oh = mh; ov = mv;
        @(negedge clk);
        bus.cnt_4ms  = 1'b1;
        bus.recenter = rc;
        if (rc) begin
            mh = CENTER; mv = CENTER; nh = 0; nv = 0;
        end else begin
            model_axis(bus.analog_en, bus.joy_left, bus.joy_right, bus.joy_x, mh, nh, hh);
            model_axis(bus.analog_en, bus.joy_up, bus.joy_down, bus.joy_y, mv, nv, hv);
        end
        upd = (mh != oh) || (mv != ov);
        @(posedge clk); #1;
        check_pos("tick", upd);
        @(negedge clk);
        bus.recenter = 1'b0;
        extra = $urandom_range(0, 2);
        repeat (extra) begin
            @(posedge clk); #1;
            check_pos("high", 1'b0);
        end
        @(negedge clk);
        bus.cnt_4ms = 1'b0;
        @(posedge clk); #1;
        check_pos("low", 1'b0);
    endtask

    task automatic ticks(input int count);
        repeat (count) do_tick(1'b0);
    endtask

    task automatic do_recenter();
        bit upd;
        @(negedge clk);
        bus.recenter = 1'b1;
        upd = (mh != CENTER) || (mv != CENTER);
        mh = CENTER; mv = CENTER; nh = 0; nv = 0;
        @(posedge clk); #1;
        check_pos("rc", upd);
        @(negedge clk);
        bus.recenter = 1'b0;
        @(posedge clk); #1;
        check_pos("rc_after", 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.cnt_4ms = 1'b0;
        model_reset();
        #1;
        check_pos("async_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_dirs(input bit l, input bit r, input bit u, input bit d);
        @(negedge clk);
        bus.joy_left = l; bus.joy_right = r; bus.joy_up = u; bus.joy_down = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.cnt_4ms = 1'b0; bus.analog_en = 1'b0; bus.recenter = 1'b0;
        bus.joy_left = 1'b0; bus.joy_right = 1'b0; bus.joy_up = 1'b0; bus.joy_down = 1'b0;
        bus.joy_x = 8'h00; bus.joy_y = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_pos("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle ticks do nothing
        ticks(10);
        chk("t1_h", 8'(bus.gun_h), 8'd32);

        // Hold right: steps on ticks 2, 6, 10
        set_dirs(0, 1, 0, 0);
        ticks(12);
        chk("t2_h", 8'(bus.gun_h), 8'd35);

        // Acceleration and saturation
        set_dirs(0, 0, 0, 0);
        ticks(1);
        do_recenter();
        set_dirs(0, 1, 0, 0);
        ticks(30);
        chk("t3_tick30", 8'(bus.gun_h), 8'd40);
        ticks(10);
        chk("t3_tick40", 8'(bus.gun_h), 8'd50);
        ticks(18);
        chk("t3_sat", 8'(bus.gun_h), 8'd63);

        // Conflicting directions and reversal
        set_dirs(0, 0, 0, 0);
        ticks(1);
        do_recenter();
        set_dirs(1, 1, 1, 1);
        ticks(10);
        chk("t4_both_h", 8'(bus.gun_h), 8'd32);
        chk("t4_both_v", 8'(bus.gun_v), 8'd32);
        set_dirs(0, 1, 0, 0);
        ticks(3);
        chk("t4_right", 8'(bus.gun_h), 8'd33);
        set_dirs(1, 0, 0, 0);
        ticks(4);
        chk("t4_left", 8'(bus.gun_h), 8'd32);

        // Analog slew to the extremes
        set_dirs(0, 0, 0, 0);
        bus.analog_en = 1'b1; bus.joy_x = 8'h7F; bus.joy_y = 8'h80;
        ticks(1);
        chk("t5_h36", 8'(bus.gun_h), 8'd36);
        ticks(7);
        chk("t5_h63", 8'(bus.gun_h), 8'd63);
        chk("t5_v0", 8'(bus.gun_v), 8'd0);
        ticks(2);

        // Recenter beats a tick; reset mid-REPEAT
        @(negedge clk);
        bus.analog_en = 1'b0; bus.joy_x = 8'h00; bus.joy_y = 8'h00;
        do_recenter();
        set_dirs(0, 1, 0, 0);
        ticks(40);
        chk("t6_h50", 8'(bus.gun_h), 8'd50);
        do_tick(1'b1);
        chk("t6_rc_tick", 8'(bus.gun_h), 8'd32);
        ticks(35);
        pulse_reset();
        chk("t6_rst_h", 8'(bus.gun_h), 8'd32);
        set_dirs(0, 0, 0, 0);
        ticks(2);

        // Randomized mix of modes, directions and recentres
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                bus.joy_left  = 1'($urandom_range(0, 1));
                bus.joy_right = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.joy_up   = 1'($urandom_range(0, 1));
                bus.joy_down = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 15) == 0) bus.analog_en = ~bus.analog_en;
            bus.joy_x = 8'($urandom);
            bus.joy_y = 8'($urandom);
            if (i == 125)
                pulse_reset();
            else if ($urandom_range(0, 24) == 0)
                do_recenter();
            else
                do_tick($urandom_range(0, 24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
